paddle_hub: RTL and testbench
=============================

// Module: paddle_hub
// PURPOSE
// - Multi-channel paddle input front-end; replaces the fixed 4-instance single-channel controllers.
// - Each channel selects its source automatically from three inputs:
//   - HPS paddle
//   - analog stick, in absolute or relative/integrating mode
//   - PS/2 mouse, routed to one selectable channel
// - Produces an 8-bit position and a fire bit per channel for the A2601 core paddle inputs.
// PARAMETERS
// - N_CH       4    number of paddle channels (1..8)
// - AXIS_THR   100  stick magnitude above which the X/Y axis latch switches
// - DEADZONE   8    stick magnitude at or below this is treated as 0 in relative mode
// - RATE_SHIFT 3    relative mode: step = axis >>> RATE_SHIFT, applied once per tick
// - TICK_DIV   4096 clk_sys cycles per relative-mode integration tick
// - MAX_STEP   10   mouse delta clamp, as magnitude
// PORTS
// - clk_sys     in   1            system clock
// - reset       in   1            synchronous, active-high reset
// - inv         in   1            invert all a_out values (bitwise NOT)
// - rel_mode    in   1            1 = stick integrates position, 0 = stick is absolute
// - stick_btn   in   N_CH         per-channel stick-select/fire button
// - paddle_btn  in   N_CH         per-channel paddle-select/fire button
// - joy_a       in   16*N_CH      per channel: [15:8] = Y, [7:0] = X, both signed
// - paddle      in   8*N_CH       per-channel HPS paddle position, unsigned
// - ps2_mouse   in   25           [24] = toggle strobe, [23:16] = dy, [15:8] = dx, [5:4] = sign bits, [1:0] = buttons
// - mouse_ch    in   $clog2(N_CH) channel that receives mouse events; sampled only on a strobe
// - a_out       out  8*N_CH       per-channel position
// - b_out       out  N_CH         per-channel fire bit
// - src         out  2*N_CH       current source per channel: 0 = PAD, 1 = STICK, 2 = MOUSE
// BEHAVIOUR
// - Reset, synchronous and active-high on clk_sys:
//   - a_out = 0, b_out = 0, src = PAD, xy latch = 0 (X axis)
//   - mouse accumulators = 0, stick integrators = 0, tick prescaler = 0, strobe history = ps2_mouse[24]
//   - Reset mid-operation discards all accumulated state.
// - Mouse strobe = ps2_mouse[24] differs from its registered copy. Exactly one event per toggle.
// - Per-channel source FSM, states PAD / STICK / MOUSE:
//   - A strobe with mouse_ch == ch moves channel ch to MOUSE.
//   - stick_btn moves the channel to STICK.
//   - paddle_btn moves the channel to PAD.
//   - Same-cycle priority: paddle_btn > stick_btn > strobe.
// - Mouse accumulation, on a strobe, for channel mouse_ch only:
//   - d = sign-extend 9 bits, clamp to [-MAX_STEP, +MAX_STEP]
//   - acc = sat(acc + d) into [-128, 127]
//   - Applied to both the X and Y accumulators, whatever the channel's current source.
//   - Other channels keep their accumulators.
// - X/Y latch:
//   - In MOUSE: button[1] sets Y, button[0] sets X. X wins if both are pressed.
//   - In STICK: Y if joy Y > +AXIS_THR (positive only), X if joy X > +AXIS_THR. X wins if both.
// - Stick absolute mode (rel_mode = 0): pre = selected axis raw.
// - Stick relative mode (rel_mode = 1):
//   - On each tick, when |axis| > DEADZONE: integ = sat8s(integ + (axis >>> RATE_SHIFT)).
//   - pre = integ.
//   - Integrators run only while the channel is in STICK.
//   - Switching rel_mode to 1 preloads integ from the current absolute axis value.
// - Prescaler: counts 0..TICK_DIV-1. Tick is asserted on wrap. Free-running, one shared prescaler.
// - pre by source:
//   - PAD: {~paddle[7], paddle[6:0]}
//   - STICK: as above
//   - MOUSE: selected accumulator [7:0]
// - Pipeline:
//   - Stage 1 registers pre.
//   - Stage 2: a_out = inv ? ~pre : pre.
//   - Latency from input change to a_out is 2 clk_sys cycles. b_out is registered with 1 cycle of latency.
// - b_out by source: PAD -> paddle_btn, STICK -> stick_btn, MOUSE -> |ps2_mouse[1:0].
// - Boundary cases:
//   - Saturation at 127 / -128 is sticky. It never wraps.
//   - If mouse_ch >= N_CH, the strobe is ignored.
//   - N_CH = 1 forces mouse_ch width to 1 and ignores the mouse_ch value.
// CONFIGURATION
// - Macro PADDLE_HUB_SMOOTH_EN:
//   - Defined: adds a stage-3 IIR, y += (x - y) >>> 2, per channel, 10-bit internal with sign extension.
//     The IIR resets to 0 and the latency to the first response becomes 3 cycles.
//   - Undefined: no stage 3; latency stays 2 cycles. Outputs are bit-identical to the unsmoothed path.
// STRUCTURE
// - Package paddle_pkg:
//   - typedef enum logic [1:0] src_t {SRC_PAD, SRC_STICK, SRC_MOUSE}
//   - function sat8s(9-bit signed) -> 8-bit signed
//   - function clamp_step
// - Sub-module paddle_chan, instantiated N_CH times in a generate loop, holds:
//   - the source FSM and xy latch
//   - the accumulators and integrator
//   - the output pipeline
// - The top level holds:
//   - strobe edge detect and mouse_ch decode into a per-channel mouse_evt
//   - the prescaler
// TESTING
// - Strobe toggle, dx = +50, mouse_ch = 2:
//   - ch2 src -> MOUSE, ch2 accX = +10 (clamped)
//   - a_out[2] = 8'h0A 2 cycles later; other channels unchanged
// - 14 strobes with dx = +10 on ch0: accX = +127 (saturated), a_out[0] = 8'h7F. With inv = 1, a_out[0] = 8'h80.
// - Same cycle on ch1: paddle_btn = 1, stick_btn = 1, strobe with mouse_ch = 1 -> src[1] = PAD, b_out[1] = 1.
// - STICK, rel_mode = 1, X = +64, RATE_SHIFT = 3:
//   - integ rises by 8 per tick, reaching 8'h40 after 8 ticks
//   - X = +5 (inside DEADZONE) leaves integ unchanged
// - STICK, absolute mode: Y = +120 -> xy = Y, a_out = 8'h78. Y = -120 does not switch the latch.
// - Reset asserted mid-accumulation: next cycle all a_out = 0, b_out = 0, src = PAD; the accumulators restart from 0.

Source files
------------

// File: rtl/paddle_hub_pkg.sv
// Shared types and arithmetic helpers for the paddle_hub input front-end.
package paddle_pkg;

  typedef enum logic [1:0] {
    SRC_PAD   = 2'd0,
    SRC_STICK = 2'd1,
    SRC_MOUSE = 2'd2
  } src_t;

  function automatic int unsigned mch_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [7:0] sat8s(logic signed [8:0] s);
    if (s > 9'sd127)       return 8'sd127;
    else if (s < -9'sd128) return -8'sd128;
    else                   return s[7:0];
  endfunction

  // Mouse deltas are bounded to +/-max_step before accumulation.
  function automatic logic signed [7:0] clamp_step(logic signed [8:0] d, int unsigned max_step);
    logic signed [8:0] lim;
    lim = $signed(9'(max_step));
    if (d > lim)       return lim[7:0];
    else if (d < -lim) return 8'(-lim);
    else               return d[7:0];
  endfunction

endpackage

// File: rtl/paddle_hub_if.sv
// Paddle hub bus: controller inputs towards the hub, per-channel results back.
interface paddle_hub_if #(
  parameter int unsigned N_CH = 4
);
  import paddle_pkg::*;

  localparam int unsigned MCW = mch_width(N_CH);

  logic                  inv;
  logic                  rel_mode;
  logic [N_CH-1:0]       stick_btn;
  logic [N_CH-1:0]       paddle_btn;
  logic [16*N_CH-1:0]    joy_a;
  logic [8*N_CH-1:0]     paddle;
  logic [24:0]           ps2_mouse;
  logic [MCW-1:0]        mouse_ch;
  logic [8*N_CH-1:0]     a_out;
  logic [N_CH-1:0]       b_out;
  logic [2*N_CH-1:0]     src;

  modport master (
    output inv, rel_mode, stick_btn, paddle_btn, joy_a, paddle, ps2_mouse, mouse_ch,
    input  a_out, b_out, src
  );

  modport slave (
    input  inv, rel_mode, stick_btn, paddle_btn, joy_a, paddle, ps2_mouse, mouse_ch,
    output a_out, b_out, src
  );

endinterface

// File: rtl/paddle_hub_chan.sv
// One paddle channel: source FSM, xy latch, mouse accumulators, stick integrator, output pipeline.
// Optional stage-3 IIR smoothing under PADDLE_HUB_SMOOTH_EN.
module paddle_chan
  import paddle_pkg::*;
#(
  parameter int unsigned AXIS_THR   = 100,
  parameter int unsigned DEADZONE   = 8,
  parameter int unsigned RATE_SHIFT = 3,
  parameter int unsigned MAX_STEP   = 10
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        inv,
  input  logic        rel_mode,
  input  logic        tick,
  input  logic        mouse_evt,
  input  logic        stick_btn,
  input  logic        paddle_btn,
  input  logic [15:0] joy,
  input  logic [7:0]  paddle,
  input  logic [8:0]  mouse_dx,
  input  logic [8:0]  mouse_dy,
  input  logic [1:0]  mouse_btn,
  output logic [7:0]  a_out,
  output logic        b_out,
  output logic [1:0]  src
);

  src_t              src_q, src_d;
  logic              xy_q, xy_d;
  logic              rel_q;
  logic              b_d;
  logic              x_hot, y_hot;
  logic signed [7:0] joy_x, joy_y;
  logic signed [7:0] acc_x, acc_y, acc_x_d, acc_y_d;
  logic signed [7:0] integ, integ_d;
  logic signed [7:0] axis_d, step_v, step_x, step_y;
  logic signed [8:0] axis9;
  logic [8:0]        axis_mag;
  logic signed [7:0] pre, pre_q, a2_q;

  assign joy_x = joy[7:0];
  assign joy_y = joy[15:8];
  assign x_hot = int'(joy_x) > int'(AXIS_THR);
  assign y_hot = int'(joy_y) > int'(AXIS_THR);
  assign src   = src_q;

  // pre is built from next-state values so every input reaches a_out in two cycles.
  always_comb begin
    src_d = src_q;
    if (paddle_btn)     src_d = SRC_PAD;
    else if (stick_btn) src_d = SRC_STICK;
    else if (mouse_evt) src_d = SRC_MOUSE;

    xy_d = xy_q;
    if (src_d == SRC_MOUSE) begin
      if (mouse_btn[0])      xy_d = 1'b0;
      else if (mouse_btn[1]) xy_d = 1'b1;
    end else if (src_d == SRC_STICK) begin
      if (x_hot)      xy_d = 1'b0;
      else if (y_hot) xy_d = 1'b1;
    end

    step_x  = clamp_step(mouse_dx, MAX_STEP);
    step_y  = clamp_step(mouse_dy, MAX_STEP);
    acc_x_d = acc_x;
    acc_y_d = acc_y;
    if (mouse_evt) begin
      acc_x_d = sat8s({acc_x[7], acc_x} + {step_x[7], step_x});
      acc_y_d = sat8s({acc_y[7], acc_y} + {step_y[7], step_y});
    end

    axis_d   = xy_d ? joy_y : joy_x;
    axis9    = {axis_d[7], axis_d};
    axis_mag = axis_d[7] ? 9'(-axis9) : 9'(axis9);
    step_v   = axis_d >>> RATE_SHIFT;
    integ_d  = integ;
    if (rel_mode && !rel_q)
      integ_d = axis_d;
    else if (rel_mode && tick && src_d == SRC_STICK && 32'(axis_mag) > DEADZONE)
      integ_d = sat8s({integ[7], integ} + {step_v[7], step_v});

    pre = {~paddle[7], paddle[6:0]};
    b_d = paddle_btn;
    case (src_d)
      SRC_STICK: begin
        pre = rel_mode ? integ_d : axis_d;
        b_d = stick_btn;
      end
      SRC_MOUSE: begin
        pre = xy_d ? acc_y_d : acc_x_d;
        b_d = |mouse_btn;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      src_q <= SRC_PAD;
      xy_q  <= 1'b0;
      rel_q <= rel_mode;
      acc_x <= '0;
      acc_y <= '0;
      integ <= '0;
      pre_q <= '0;
      a2_q  <= '0;
      b_out <= 1'b0;
    end else begin
      src_q <= src_d;
      xy_q  <= xy_d;
      rel_q <= rel_mode;
      acc_x <= acc_x_d;
      acc_y <= acc_y_d;
      integ <= integ_d;
      pre_q <= pre;
      a2_q  <= inv ? ~pre_q : pre_q;
      b_out <= b_d;
    end
  end

`ifdef PADDLE_HUB_SMOOTH_EN
  logic signed [9:0] iir_q, iir_x, iir_diff;
  logic              unused_iir;

  assign iir_x      = {{2{a2_q[7]}}, a2_q};
  assign iir_diff   = iir_x - iir_q;
  assign unused_iir = ^iir_q[9:8];

  always_ff @(posedge clk_sys) begin
    if (reset) iir_q <= '0;
    else       iir_q <= iir_q + (iir_diff >>> 2);
  end

  assign a_out = iir_q[7:0];
`else
  assign a_out = a2_q;
`endif

endmodule

// File: rtl/paddle_hub.sv
// Multi-channel paddle front-end: mouse strobe detect, channel decode, shared tick prescaler.
// Optional per-channel output smoothing under macro PADDLE_HUB_SMOOTH_EN.
module paddle_hub
  import paddle_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned AXIS_THR   = 100,
  parameter int unsigned DEADZONE   = 8,
  parameter int unsigned RATE_SHIFT = 3,
  parameter int unsigned TICK_DIV   = 4096,
  parameter int unsigned MAX_STEP   = 10
) (
  input logic         clk_sys,
  input logic         reset,
  paddle_hub_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic            strobe_q;
  logic            strobe;
  logic [PW-1:0]   pcnt;
  logic            tick;
  logic [N_CH-1:0] mouse_evt;
  logic [8:0]      mouse_dx, mouse_dy;
  logic            unused_ps2;

  assign strobe     = bus.ps2_mouse[24] ^ strobe_q;
  assign tick       = (pcnt == PW'(TICK_DIV - 1));
  assign mouse_dx   = {bus.ps2_mouse[4], bus.ps2_mouse[15:8]};
  assign mouse_dy   = {bus.ps2_mouse[5], bus.ps2_mouse[23:16]};
  assign unused_ps2 = ^{bus.ps2_mouse[7:6], bus.ps2_mouse[3:2]};

  always_ff @(posedge clk_sys) begin
    strobe_q <= bus.ps2_mouse[24];
    if (reset || tick) pcnt <= '0;
    else               pcnt <= pcnt + 1'b1;
  end

  // Out-of-range mouse_ch matches no channel, so the event is dropped.
  always_comb begin
    mouse_evt = '0;
    for (int unsigned c = 0; c < N_CH; c++)
      if (N_CH == 1 || 32'(bus.mouse_ch) == c) mouse_evt[c] = strobe;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    paddle_chan #(
      .AXIS_THR   (AXIS_THR),
      .DEADZONE   (DEADZONE),
      .RATE_SHIFT (RATE_SHIFT),
      .MAX_STEP   (MAX_STEP)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .inv        (bus.inv),
      .rel_mode   (bus.rel_mode),
      .tick       (tick),
      .mouse_evt  (mouse_evt[c]),
      .stick_btn  (bus.stick_btn[c]),
      .paddle_btn (bus.paddle_btn[c]),
      .joy        (bus.joy_a[16*c +: 16]),
      .paddle     (bus.paddle[8*c +: 8]),
      .mouse_dx   (mouse_dx),
      .mouse_dy   (mouse_dy),
      .mouse_btn  (bus.ps2_mouse[1:0]),
      .a_out      (bus.a_out[8*c +: 8]),
      .b_out      (bus.b_out[c]),
      .src        (bus.src[2*c +: 2])
    );
  end

endmodule

// File: tb/tb_paddle_hub.sv
// Directed scoreboard bench for paddle_hub (4 channels, default parameters).
module tb_paddle_hub;
  import paddle_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned TD  = 4096;
  localparam int K_A = 0, K_B = 1, K_SRC = 2;

  typedef struct {
    string       tag;
    int          kind;
    int          ch;
    logic [7:0]  exp;
    int unsigned due;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        strobe_bit = 1'b0;
  int unsigned cyc = 0;
  int unsigned pcnt_m = 0;
  int unsigned ticks = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sbq[$];

  paddle_hub_if #(.N_CH(NCH)) bus ();

  paddle_hub #(
    .N_CH(NCH), .AXIS_THR(100), .DEADZONE(8), .RATE_SHIFT(3), .TICK_DIV(TD), .MAX_STEP(10)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Independent model of the shared integration tick.
  always @(posedge clk_sys) begin
    if (reset) pcnt_m <= 0;
    else if (pcnt_m == TD - 1) begin
      pcnt_m <= 0;
      ticks  <= ticks + 1;
    end else pcnt_m <= pcnt_m + 1;
  end

  function automatic logic [24:0] mk_ps2(logic stb, logic signed [8:0] dx,
                                         logic signed [8:0] dy, logic [1:0] btn);
    return {stb, dy[7:0], dx[7:0], 2'b00, dy[8], dx[8], 2'b00, btn};
  endfunction

  function automatic logic [7:0] observe(int kind, int ch);
    case (kind)
      K_A:     return bus.a_out[8*ch +: 8];
      K_B:     return {7'd0, bus.b_out[ch]};
      default: return {6'd0, bus.src[2*ch +: 2]};
    endcase
  endfunction

  task automatic push_exp(string tag, int kind, int ch, logic [7:0] v, int unsigned lat);
    exp_t e;
    e.tag = tag; e.kind = kind; e.ch = ch; e.exp = v; e.due = cyc + lat;
    sbq.push_back(e);
  endtask

  task automatic step(int unsigned n);
    exp_t       e;
    logic [7:0] obs;
    int         i;
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk_sys);
      cyc++;
      @(negedge clk_sys);
      i = 0;
      while (i < sbq.size()) begin
        if (sbq[i].due <= cyc) begin
          e   = sbq[i];
          obs = observe(e.kind, e.ch);
          checks++;
          assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s ch%0d: got %h expected %h", e.tag, e.ch, obs, e.exp);
          end
          sbq.delete(i);
        end else i++;
      end
    end
  endtask

  task automatic mouse(int ch, logic signed [8:0] dx, logic signed [8:0] dy, logic [1:0] btn);
    strobe_bit    = ~strobe_bit;
    bus.mouse_ch  = 2'(ch);
    bus.ps2_mouse = mk_ps2(strobe_bit, dx, dy, btn);
  endtask

  task automatic set_joy(int ch, logic signed [7:0] x, logic signed [7:0] y);
    bus.joy_a[16*ch +: 16] = {y, x};
  endtask

  task automatic wait_ticks(int unsigned n);
    int unsigned target;
    target = ticks + n;
    for (int unsigned g = 0; g < n * TD + 16 && ticks < target; g++) step(1);
  endtask

  initial begin
    bus.inv = 1'b0; bus.rel_mode = 1'b0; bus.stick_btn = '0; bus.paddle_btn = '0;
    bus.joy_a = '0; bus.paddle = '0; bus.ps2_mouse = '0; bus.mouse_ch = '0;

    // Reset state
    step(1);
    for (int c = 0; c < NCH; c++) begin
      push_exp("reset_a", K_A, c, 8'h00, 1);
      push_exp("reset_b", K_B, c, 8'h00, 1);
      push_exp("reset_src", K_SRC, c, 8'h00, 1);
    end
    step(1);

    // PAD source: MSB flipped
    bus.paddle = {8'hF0, 8'h05, 8'h80, 8'h33};
    reset = 1'b0;
    push_exp("pad", K_A, 0, 8'hB3, 2);
    push_exp("pad", K_A, 1, 8'h00, 2);
    push_exp("pad", K_A, 2, 8'h85, 2);
    push_exp("pad", K_A, 3, 8'h70, 2);
    step(2);

    // Mouse dx=+50 on ch2, clamped to +10
    mouse(2, 9'sd50, 9'sd0, 2'b00);
    push_exp("mouse_src", K_SRC, 2, 8'h02, 1);
    push_exp("mouse_b", K_B, 2, 8'h00, 1);
    push_exp("mouse_clamp", K_A, 2, 8'h0A, 2);
    push_exp("mouse_other", K_A, 0, 8'hB3, 2);
    push_exp("mouse_other", K_A, 3, 8'h70, 2);
    step(2);
    push_exp("one_evt_per_toggle", K_A, 2, 8'h0A, 3);
    step(3);

    // Positive saturation on ch0, then inversion
    for (int i = 0; i < 14; i++) begin
      mouse(0, 9'sd10, 9'sd0, 2'b00);
      step(1);
    end
    push_exp("sat_pos", K_A, 0, 8'h7F, 2);
    step(2);
    bus.inv = 1'b1;
    push_exp("inv_mouse", K_A, 0, 8'h80, 2);
    push_exp("inv_pad", K_A, 1, 8'hFF, 2);
    push_exp("inv_ch2", K_A, 2, 8'hF5, 2);
    step(2);
    bus.inv = 1'b0;

    // Negative clamp and sticky saturation
    for (int i = 0; i < 28; i++) begin
      mouse(0, -9'sd200, 9'sd0, 2'b00);
      step(1);
    end
    push_exp("sat_neg", K_A, 0, 8'h80, 2);
    step(2);

    // Mouse buttons steer the xy latch; X wins
    bus.ps2_mouse[1:0] = 2'b10;
    push_exp("mouse_btn_b", K_B, 0, 8'h01, 1);
    push_exp("latch_y_accy", K_A, 0, 8'h00, 2);
    step(2);
    bus.ps2_mouse[1:0] = 2'b11;
    push_exp("latch_x_wins", K_A, 0, 8'h80, 2);
    step(2);
    bus.ps2_mouse[1:0] = 2'b00;
    push_exp("mouse_btn_off", K_B, 0, 8'h00, 1);
    step(1);

    // Same-cycle priority on ch1
    bus.paddle_btn[1] = 1'b1; bus.stick_btn[1] = 1'b1;
    mouse(1, 9'sd3, 9'sd0, 2'b00);
    push_exp("prio_pad_src", K_SRC, 1, 8'h00, 1);
    push_exp("prio_pad_b", K_B, 1, 8'h01, 1);
    step(1);
    bus.paddle_btn[1] = 1'b0;
    mouse(1, 9'sd3, 9'sd0, 2'b00);
    push_exp("prio_stick_src", K_SRC, 1, 8'h01, 1);
    push_exp("prio_stick_b", K_B, 1, 8'h01, 1);
    step(1);
    bus.stick_btn[1] = 1'b0;
    mouse(1, 9'sd3, 9'sd0, 2'b00);
    push_exp("mouse_src_ch1", K_SRC, 1, 8'h02, 1);
    push_exp("mouse_b_ch1", K_B, 1, 8'h00, 1);
    push_exp("acc_any_src", K_A, 1, 8'h09, 2);
    step(2);

    // Stick absolute on ch3
    set_joy(3, 8'sd0, 8'sd120);
    bus.stick_btn[3] = 1'b1;
    push_exp("stick_src", K_SRC, 3, 8'h01, 1);
    push_exp("stick_b", K_B, 3, 8'h01, 1);
    push_exp("stick_abs_y", K_A, 3, 8'h78, 2);
    step(1);
    bus.stick_btn[3] = 1'b0;
    push_exp("stick_b_rel", K_B, 3, 8'h00, 1);
    step(1);
    set_joy(3, 8'sd0, -8'sd120);
    push_exp("neg_y_no_switch", K_A, 3, 8'h88, 2);
    step(2);
    set_joy(3, 8'sd110, -8'sd120);
    push_exp("latch_x", K_A, 3, 8'h6E, 2);
    step(2);
    set_joy(3, 8'sd0, 8'sd120);
    push_exp("latch_y_again", K_A, 3, 8'h78, 2);
    step(2);
    set_joy(3, 8'sd100, 8'sd30);
    push_exp("thr_not_above", K_A, 3, 8'h1E, 2);
    step(2);
    set_joy(3, 8'sd120, 8'sd0);
    push_exp("latch_x_120", K_A, 3, 8'h78, 2);
    step(2);

    // Relative mode integration on ch3
    set_joy(3, 8'sd0, 8'sd0);
    bus.rel_mode = 1'b1;
    push_exp("rel_preload", K_A, 3, 8'h00, 2);
    step(2);
    set_joy(3, 8'sd64, 8'sd0);
    wait_ticks(8);
    push_exp("rel_8_ticks", K_A, 3, 8'h40, 2);
    step(2);
    set_joy(3, 8'sd5, 8'sd0);
    wait_ticks(2);
    push_exp("rel_deadzone", K_A, 3, 8'h40, 2);
    step(2);
    set_joy(3, -8'sd100, 8'sd0);
    wait_ticks(1);
    push_exp("rel_negative", K_A, 3, 8'h33, 2);
    step(2);

    // Reset mid-operation discards all state
    bus.rel_mode = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      push_exp("mid_reset_a", K_A, c, 8'h00, 1);
      push_exp("mid_reset_b", K_B, c, 8'h00, 1);
      push_exp("mid_reset_src", K_SRC, c, 8'h00, 1);
    end
    step(1);
    reset = 1'b0;
    mouse(0, 9'sd10, 9'sd0, 2'b00);
    push_exp("post_reset_src", K_SRC, 0, 8'h02, 1);
    push_exp("post_reset_acc", K_A, 0, 8'h0A, 2);
    push_exp("post_reset_pad", K_A, 3, 8'h70, 2);
    step(3);

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
